// File: rtl/mac_timing_pkg.sv
// Raster geometry, RAM buffer offsets and bus slot encoding shared by the Mac video timing block.
package mac_timing_pkg;

    localparam logic [8:0] H_ACTIVE = 9'd256;
    localparam logic [8:0] H_TOTAL  = 9'd352;
    localparam logic [8:0] V_ACTIVE = 9'd342;
    localparam logic [8:0] V_TOTAL  = 9'd370;

    localparam logic [22:0] MEM_TOP         = 23'h400000;
    localparam logic [22:0] SCREEN_OFS_MAIN = 23'h005900;
    localparam logic [22:0] SCREEN_OFS_ALT  = 23'h00D900;
    localparam logic [22:0] SOUND_OFS_MAIN  = 23'h000300;
    localparam logic [22:0] SOUND_OFS_ALT   = 23'h005F00;

    // The four clk8 phases of one RAM access window.
    typedef enum logic [1:0] {
        SLOT_VID0 = 2'd0,
        SLOT_VID1 = 2'd1,
        SLOT_CPU0 = 2'd2,
        SLOT_CPU1 = 2'd3
    } slot_e;

    // vid_main follows the VIA PA6 sense: 1 selects the main screen buffer.
    function automatic logic [21:0] screen_base(input logic vid_main);
        logic [22:0] base;
        base = MEM_TOP - (vid_main ? SCREEN_OFS_MAIN : SCREEN_OFS_ALT);
        return base[21:0];
    endfunction

    function automatic logic [21:0] sound_base(input logic snd_alt_sel);
        logic [22:0] base;
        base = MEM_TOP - (snd_alt_sel ? SOUND_OFS_ALT : SOUND_OFS_MAIN);
        return base[21:0];
    endfunction

endpackage

// File: rtl/mac_raster_counter.sv
// Horizontal/vertical raster position; exposes the position the next clk8 step will move to.
module mac_raster_counter
    import mac_timing_pkg::*;
#(
    parameter logic [8:0] H_TOT = H_TOTAL,
    parameter logic [8:0] V_TOT = V_TOTAL
) (
    input  logic       clk32,
    input  logic       _systemReset,
    input  logic       advance,
    output logic [1:0] bus_cycle,
    output logic [8:0] hcount_next,
    output logic [8:0] vcount_next,
    output logic       frame_wrap
);

    logic [8:0] hcount_reg;
    logic [8:0] vcount_reg;
    logic       line_wrap;

    // Next position is computed unconditionally; the owner of advance decides when it lands.
    always_comb begin
        line_wrap   = (hcount_reg == H_TOT - 9'd1);
        frame_wrap  = line_wrap && (vcount_reg == V_TOT - 9'd1);
        hcount_next = line_wrap ? 9'd0 : hcount_reg + 9'd1;
        vcount_next = vcount_reg;
        if (line_wrap) begin
            vcount_next = frame_wrap ? 9'd0 : vcount_reg + 9'd1;
        end
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            hcount_reg <= 9'd0;
            vcount_reg <= 9'd0;
        end else if (advance) begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    assign bus_cycle = hcount_reg[1:0];

endmodule

// File: rtl/mac_video_timing.sv
// Mac raster timing and RAM slot generator: blanking, video/CPU bus split, memory latch strobe,
// and the RAM byte address of each pixel-word and sound-sample fetch.
module mac_video_timing
    import mac_timing_pkg::*;
#(
    parameter logic [8:0] H_ACT = H_ACTIVE,
    parameter logic [8:0] H_TOT = H_TOTAL,
    parameter logic [8:0] V_ACT = V_ACTIVE,
    parameter logic [8:0] V_TOT = V_TOTAL
) (
    input  logic        clk32,
    input  logic        _systemReset,
    input  logic        clk8_en_p,
    input  logic        clk8_en_n,
    input  logic        vid_alt,
    input  logic        snd_alt,
    output logic        _hblank,
    output logic        _vblank,
    output logic        videoBusControl,
    output logic        cpuBusControl,
    output logic        memoryLatch,
    output logic        loadPixels,
    output logic        loadSound,
    output logic [21:0] videoAddr
);

    // Sound sample is fetched in the second phase of the access window starting at H_ACT+4.
    localparam logic [8:0] SOUND_HCOUNT = H_ACT + 9'd5;

    logic [1:0]  bus_cycle;
    logic [8:0]  hcount_next;
    logic [8:0]  vcount_next;
    logic        frame_wrap;

    slot_e       slot_now;
    slot_e       slot_next;
    logic        vid_main_reg;
    logic        vid_main_next;
    logic        snd_alt_reg;
    logic        snd_alt_next;
    logic        mem_latch_next;
    logic        load_pixels_next;
    logic        load_sound_next;
    logic [21:0] video_addr_next;

    logic        hblank_n_reg;
    logic        vblank_n_reg;
    logic        vid_bus_reg;
    logic        cpu_bus_reg;
    logic        mem_latch_reg;
    logic        load_pixels_reg;
    logic        load_sound_reg;
    logic [21:0] video_addr_reg;

    mac_raster_counter #(
        .H_TOT (H_TOT),
        .V_TOT (V_TOT)
    ) u_raster (
        .clk32        (clk32),
        ._systemReset (_systemReset),
        .advance      (clk8_en_p),
        .bus_cycle    (bus_cycle),
        .hcount_next  (hcount_next),
        .vcount_next  (vcount_next),
        .frame_wrap   (frame_wrap)
    );

    always_comb begin
        slot_now  = slot_e'(bus_cycle);
        slot_next = slot_e'(hcount_next[1:0]);

        // Buffer selects only move at the frame boundary so a frame never mixes buffers.
        vid_main_next = frame_wrap ? vid_alt : vid_main_reg;
        snd_alt_next  = frame_wrap ? snd_alt : snd_alt_reg;

        load_pixels_next = (slot_next == SLOT_VID1) && !hcount_next[2] &&
                           (hcount_next < H_ACT) && (vcount_next < V_ACT);
        load_sound_next  = (hcount_next == SOUND_HCOUNT);

        if (load_sound_next) begin
            video_addr_next = sound_base(snd_alt_next) + {12'd0, vcount_next, 1'b0};
        end else begin
            video_addr_next = screen_base(vid_main_next) + {7'd0, vcount_next, 6'd0}
                              + {16'd0, hcount_next[7:3], 1'b0};
        end

        // A coincident positive phase means the slot is moving; no data is valid to latch.
        mem_latch_next = clk8_en_n && !clk8_en_p &&
                         ((slot_now == SLOT_VID1) || (slot_now == SLOT_CPU1));
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            vid_main_reg    <= 1'b1;
            snd_alt_reg     <= 1'b0;
            hblank_n_reg    <= 1'b1;
            vblank_n_reg    <= 1'b1;
            vid_bus_reg     <= 1'b1;
            cpu_bus_reg     <= 1'b0;
            mem_latch_reg   <= 1'b0;
            load_pixels_reg <= 1'b0;
            load_sound_reg  <= 1'b0;
            video_addr_reg  <= screen_base(1'b1);
        end else begin
            mem_latch_reg <= mem_latch_next;
            if (clk8_en_p) begin
                vid_main_reg    <= vid_main_next;
                snd_alt_reg     <= snd_alt_next;
                hblank_n_reg    <= (hcount_next < H_ACT);
                vblank_n_reg    <= (vcount_next < V_ACT);
                vid_bus_reg     <= (slot_next == SLOT_VID0) || (slot_next == SLOT_VID1);
                cpu_bus_reg     <= (slot_next == SLOT_CPU0) || (slot_next == SLOT_CPU1);
                load_pixels_reg <= load_pixels_next;
                load_sound_reg  <= load_sound_next;
                video_addr_reg  <= video_addr_next;
            end
        end
    end

    assign _hblank         = hblank_n_reg;
    assign _vblank         = vblank_n_reg;
    assign videoBusControl = vid_bus_reg;
    assign cpuBusControl   = cpu_bus_reg;
    assign memoryLatch     = mem_latch_reg;
    assign loadPixels      = load_pixels_reg;
    assign loadSound       = load_sound_reg;
    assign videoAddr       = video_addr_reg;

endmodule

// File: tb/tb_mac_video_timing.sv
// Self-checking bench for mac_video_timing: random clk8 enable spacing against a raster model
// derived from the absolute clk8 tick count, plus directed frame/line/reset checks.
module tb_mac_video_timing;

    // Full line geometry, shortened frame so several frame wraps fit the cycle budget.
    localparam int HA    = 256;
    localparam int HT    = 352;
    localparam int VA    = 12;
    localparam int VT    = 16;
    localparam int FRAME = HT * VT;

    logic        clk32;
    logic        _systemReset;
    logic        clk8_en_p;
    logic        clk8_en_n;
    logic        vid_alt;
    logic        snd_alt;
    logic        _hblank;
    logic        _vblank;
    logic        videoBusControl;
    logic        cpuBusControl;
    logic        memoryLatch;
    logic        loadPixels;
    logic        loadSound;
    logic [21:0] videoAddr;

    mac_video_timing #(
        .H_ACT (9'(HA)),
        .H_TOT (9'(HT)),
        .V_ACT (9'(VA)),
        .V_TOT (9'(VT))
    ) dut (
        .clk32           (clk32),
        ._systemReset    (_systemReset),
        .clk8_en_p       (clk8_en_p),
        .clk8_en_n       (clk8_en_n),
        .vid_alt         (vid_alt),
        .snd_alt         (snd_alt),
        ._hblank         (_hblank),
        ._vblank         (_vblank),
        .videoBusControl (videoBusControl),
        .cpuBusControl   (cpuBusControl),
        .memoryLatch     (memoryLatch),
        .loadPixels      (loadPixels),
        .loadSound       (loadSound),
        .videoAddr       (videoAddr)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: clk8 ticks since reset and the buffer selects in force for the current frame.
    int   tick = 0;
    logic m_vid = 1'b1;
    logic m_snd = 1'b0;
    logic exp_ml = 1'b0;

    int   vb_low = 0, lp_cnt = 0, ls_cnt = 0;
    int   ml_cnt = 0, ml_wide = 0;
    logic ml_prev = 1'b0;
    logic cap = 1'b0;
    logic [21:0] pix_q[$];
    logic [21:0] snd_addr = '0;
    logic        snd_hb = 1'b1;
    int          snd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (tick %0d)", tag, obs, exp, tick);
        end
    endtask

    function automatic logic [31:0] expected_vec();
        int h, v, base;
        logic hb, vb, vbc, lp, ls;
        logic [21:0] a;
        h   = tick % HT;
        v   = (tick / HT) % VT;
        hb  = (h < HA);
        vb  = (v < VA);
        vbc = ((h % 4) < 2);
        lp  = (h % 4 == 1) && ((h / 4) % 2 == 0) && hb && vb;
        ls  = (h % 4 == 1) && (h / 4 == (HA + 4) / 4);
        a   = '0;
        if (ls) begin
            base = m_snd ? ('h400000 - 'h5F00) : ('h400000 - 'h0300);
            a    = 22'(base + 2 * v);
        end else if (lp) begin
            base = m_vid ? ('h400000 - 'h5900) : ('h400000 - 'hD900);
            a    = 22'(base + 64 * v + 2 * (h / 8));
        end
        return {3'b0, hb, vb, vbc, !vbc, exp_ml, lp, ls, a};
    endfunction

    task automatic step(input logic p, input logic n);
        int hp;
        logic [31:0] e, o;
        clk8_en_p = p;
        clk8_en_n = n;
        hp = tick % HT;
        @(posedge clk32);
        exp_ml = n && !p && ((hp % 4 == 1) || (hp % 4 == 3));
        if (p) begin
            tick++;
            if (tick % FRAME == 0) begin
                m_vid = vid_alt;
                m_snd = snd_alt;
            end
        end
        #1;
        e = expected_vec();
        o = {3'b0, _hblank, _vblank, videoBusControl, cpuBusControl, memoryLatch, loadPixels,
             loadSound, (e[23] | e[22]) ? videoAddr : 22'd0};
        check("cycle", o, e);
        if (p) begin
            if (!_vblank)  vb_low++;
            if (loadPixels) lp_cnt++;
            if (loadSound)  ls_cnt++;
            if (cap && loadPixels) pix_q.push_back(videoAddr);
            if (cap && loadSound) begin
                snd_addr = videoAddr;
                snd_hb   = _hblank;
                snd_seen++;
            end
        end
        if (memoryLatch) ml_cnt++;
        if (memoryLatch && ml_prev) ml_wide++;
        ml_prev = memoryLatch;
    endtask

    // One clk8 period with random spacing; rarely both enables coincide.
    task automatic clk8_random();
        if ($urandom_range(0, 63) == 0) step(1'b1, 1'b1);
        else                            step(1'b1, 1'b0);
        repeat ($urandom_range(0, 1)) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat ($urandom_range(0, 1)) step(1'b0, 1'b0);
    endtask

    initial begin
        logic snd1;
        int   target;

        _systemReset = 1'b0;
        clk8_en_p    = 1'b0;
        clk8_en_n    = 1'b0;
        vid_alt      = 1'b1;
        snd_alt      = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        check("reset_addr", 32'(videoAddr), 32'h3FA700);
        @(negedge clk32);
        _systemReset = 1'b1;
        repeat (4) step(1'b0, 1'b0);

        // Frame 0, line 0 on the main buffer.
        cap = 1'b1;
        while (tick < HT) clk8_random();
        cap = 1'b0;
        check("line0_fetches", 32'(pix_q.size()), 32'd32);
        for (int k = 0; k < 32 && k < pix_q.size(); k++)
            check("line0_addr", 32'(pix_q[k]), 32'h3FA700 + 32'(2 * k));
        check("line0_snd_seen", 32'(snd_seen), 32'd1);
        check("line0_snd_addr", 32'(snd_addr), 32'h3FFD00);
        check("line0_snd_hblank", 32'(snd_hb), 32'd0);

        // Regular enable cadence: 4 clk8 periods carry exactly two single-cycle latches.
        ml_cnt = 0; ml_wide = 0; ml_prev = 1'b0;
        repeat (4) begin
            step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        end
        check("latch_count", 32'(ml_cnt), 32'd2);
        check("latch_width", 32'(ml_wide), 32'd0);

        // Change buffer selects mid-frame; they must wait for the next frame.
        while (tick < FRAME / 2) clk8_random();
        vid_alt = 1'b0;
        snd1    = 1'($urandom_range(0, 1));
        snd_alt = snd1;
        while (tick < FRAME - HT) clk8_random();
        pix_q.delete();
        snd_seen = 0;
        cap = 1'b1;
        while (tick < FRAME) clk8_random();
        cap = 1'b0;
        check("last_line_fetches", 32'(pix_q.size()), 32'd0);
        check("last_line_snd_addr", 32'(snd_addr), 32'h3FFD00 + 32'(2 * (VT - 1)));
        check("frame_vblank_clk8", 32'(vb_low), 32'((VT - VA) * HT));
        check("frame_pixel_loads", 32'(lp_cnt), 32'(32 * VA));
        check("frame_sound_loads", 32'(ls_cnt), 32'(VT));

        // Frame 1, line 0 picks up the selects sampled at the wrap.
        pix_q.delete();
        snd_seen = 0;
        cap = 1'b1;
        while (tick < FRAME + HT) clk8_random();
        cap = 1'b0;
        check("f1_line0_fetches", 32'(pix_q.size()), 32'd32);
        if (pix_q.size() > 0) check("f1_line0_first", 32'(pix_q[0]), 32'h3F2700);
        check("f1_snd_addr", 32'(snd_addr), snd1 ? 32'h3FA100 : 32'h3FFD00);

        // Random select churn for a few lines, then stop at hcount 100.
        for (int l = 0; l < 4; l++) begin
            vid_alt = 1'($urandom_range(0, 1));
            snd_alt = 1'($urandom_range(0, 1));
            target  = tick + HT;
            while (tick < target) clk8_random();
        end
        vid_alt = 1'b0;
        while (tick % HT != 100) clk8_random();

        // Asynchronous reset mid-line: outputs change without waiting for a clock edge.
        #1;
        _systemReset = 1'b0;
        #1;
        check("async_reset", {3'b0, _hblank, _vblank, videoBusControl, cpuBusControl, memoryLatch,
                              loadPixels, loadSound, videoAddr},
              {3'b0, 7'b1110000, 22'h3FA700});
        tick = 0; m_vid = 1'b1; m_snd = 1'b0; exp_ml = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk32);
        _systemReset = 1'b1;
        pix_q.delete();
        cap = 1'b1;
        while (tick < HT) clk8_random();
        cap = 1'b0;
        check("post_reset_fetches", 32'(pix_q.size()), 32'd32);
        if (pix_q.size() > 0) check("post_reset_first", 32'(pix_q[0]), 32'h3FA700);
        while (tick < 2 * HT) clk8_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
